// File: rtl/parallel_out_bank.sv
// parallel_out_bank: memory-mapped multi-channel output registers with set/clear/toggle, timed pulses and readback
module parallel_out_bank #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int AW = 8,
  parameter logic [AW-1:0] BASE = 8'hC0,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN,
  input  logic [AW-1:0]        Address,
  input  logic [WIDTH-1:0]     RegData,
  output logic [NCH*WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0]     RdData,
  output logic [NCH-1:0]       Busy
);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [AW:0] SPAN = (AW+1)'(NCH * 8);
  typedef enum logic {IDLE, PULSE} st_t;
  logic [AW:0] off;
  logic hit;
  logic [CHW-1:0] ch;
  logic [2:0] op;
  logic [WIDTH-1:0] eff [NCH];
  assign off = {1'b0, Address} - {1'b0, BASE};
  assign hit = off < SPAN;
  assign ch = off[3 +: CHW];
  assign op = Address[2:0];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    st_t s, s_nx;
    logic [WIDTH-1:0] r, r_nx, m, m_nx;
    logic [CNTW-1:0] l, l_nx, c, c_nx;
    logic wr, go, ex;
    assign wr = EN && hit && ch == CHW'(i);
    assign go = wr && op == 3'd4 && l != '0;
    assign ex = s == PULSE && c <= CNTW'(1);
    always_comb begin
      r_nx = !wr ? r :
             op == 3'd0 ? RegData :
             op == 3'd1 ? r | RegData :
             op == 3'd2 ? r & ~RegData :
             op == 3'd3 ? r ^ RegData : r;
      s_nx = go ? PULSE : ex ? IDLE : s;
      m_nx = go ? RegData : ex ? '0 : m;
      c_nx = go ? l : s == PULSE ? (ex ? '0 : c - CNTW'(1)) : c;
      l_nx = wr && op == 3'd5 ? CNTW'(RegData) : l;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s <= IDLE;
        r <= '0;
        m <= '0;
        l <= CNTW'(1);
        c <= '0;
      end else begin
        s <= s_nx;
        r <= r_nx;
        m <= m_nx;
        l <= l_nx;
        c <= c_nx;
      end
    assign eff[i] = r ^ m;
    assign DataOut[i*WIDTH +: WIDTH] = eff[i];
    assign Busy[i] = s == PULSE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) RdData <= '0;
    else RdData <= hit ? eff[ch] : '0;
endmodule

// File: doc/parallel_out_bank.md
# parallel_out_bank

Multi-channel, memory-mapped parallel output peripheral for the RV32I single-cycle core, the parametrised successor of the single-register parallel output port. It decodes an address window on the data-memory write path and exposes NCH independent WIDTH-bit output registers. Each channel supports write, set, clear and toggle operations, a timed pulse mode driven by a per-channel down-counter, and a registered readback path.

## Interface
- WIDTH, 8: bits per output channel; also the width of RegData and RdData.
- NCH, 4: number of channels, power of two, 1..16.
- AW, 8: Address width.
- BASE, 8'hC0: window base address. Must be aligned to NCH*8.
- CNTW, 8: pulse length/counter width.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- EN  in  1  write strobe; a write is sampled on the rising edge when EN=1.
- Address  in  AW  byte address; decoded as ch=(Address-BASE)>>3, op=Address[2:0].
- RegData  in  WIDTH  write data.
- DataOut  out  NCH*WIDTH  effective outputs; channel c occupies bits [c*WIDTH +: WIDTH].
- RdData  out  WIDTH  registered readback of the effective output of the addressed channel.
- Busy  out  NCH  per-channel pulse-in-progress flag.

## Operation
- Hit: BASE <= Address < BASE+NCH*8. A miss ignores the write, leaves all state unchanged, and returns RdData=0.
- Per-channel state: base register R, pulse mask M, length register L, counter C. The channel FSM has two states, IDLE and PULSE.
- op 0 WRITE: R <= RegData.
- op 1 SET: R <= R | RegData.
- op 2 CLR: R <= R & ~RegData.
- op 3 TOG: R <= R ^ RegData.
- op 4 PULSE:
  - If L=0, the write is ignored.
  - Otherwise M <= RegData, C <= L, and the FSM goes to PULSE.
  - A PULSE issued while already in PULSE restarts the pulse with the new mask and a full reload of L.
- op 5 LEN: L <= RegData zero-extended or truncated to CNTW. L takes effect from the next PULSE; a pulse already running is unaffected.
- op 6, 7: reserved. No effect; readback still works.
- Effective output per channel: DataOut = R ^ M in PULSE, and R in IDLE. In IDLE, M is held at 0.
- In PULSE, C decrements every cycle. On the edge where C=1, the FSM goes to IDLE, M <= 0 and C <= 0.
- WRITE/SET/CLR/TOG during PULSE modify R only. The pulse continues, and the output shows the new R ^ M.
- Busy[c] = 1 exactly while channel c is in PULSE.
- Readback: on every edge, RdData <= the effective output of channel ch on a hit, or 0 on a miss. EN is not required.

## Timing
- Reset (asynchronous, immediate):
  - R=0, M=0, C=0, L=1, all FSMs IDLE.
  - DataOut=0, Busy=0, RdData=0.
- Write latency: DataOut updates one edge after a write is sampled, with no combinational path from RegData/Address to DataOut.
- Pulse length: a PULSE sampled at edge k with L=n drives R^M from edge k through edge k+n, i.e. exactly n cycles. Busy is high over the same window.
- Simultaneous expiry and write on the same edge:
  - Expiry plus WRITE/SET/CLR/TOG: the write lands in R and the pulse ends, so the output becomes the new R.
  - Expiry plus PULSE: the restart wins, and Busy stays high with no gap.
- Readback latency: RdData reflects the effective output one edge after Address is presented. A same-edge write is not included; it appears the following cycle.
- Reset asserted mid-pulse: the pulse is aborted at once and the output is 0. After release the channel is IDLE with L=1.
- Counter width: L=2^CNTW-1 is the maximum. The counter must not wrap; it stops at 0.

## Test plan
- Reset then idle: rst=1 for 2 cycles, release -> DataOut=0, Busy=0, RdData=0; reading 8'hC0 returns 0.
- Channel ops on ch1 (WIDTH=8): WRITE 8'hAA at 8'hC8, SET 8'h05 at 8'hC9, CLR 8'h80 at 8'hCA, TOG 8'hFF at 8'hCB -> ch1 output 8'hAA, 8'hAF, 8'h2F, 8'hD0 on successive edges; other channels stay 0.
- Pulse on ch2: LEN 3 at 8'hD5, R=8'h0F, PULSE 8'hF0 at 8'hD4 -> DataOut[23:16]=8'hFF and Busy[2]=1 for exactly 3 cycles, then 8'h0F and Busy[2]=0. PULSE with LEN 0 -> no change.
- Restart and collisions: PULSE at the expiry edge -> no Busy gap and the new mask is shown. TOG 8'h01 during a pulse -> the output tracks (R^1)^M.
- Address window: writes to 8'hBF, 8'hE0 and reserved ops 6/7 -> no state change; reads of out-of-window addresses -> RdData=0.
- Reset mid-pulse: assert rst at cycle 2 of an L=10 pulse -> DataOut=0 and Busy=0 immediately, without waiting for a clock edge; after release, a new PULSE lasts 1 cycle because L=1.
